axi_core_arbiter: RTL and testbench

- Sequences the pipeline core's three memory requesters onto one AXI4-Lite-style master port:
  - store (data write)
  - load (data read)
  - instruction fetch
- Issues one transaction at a time and holds the pipeline via core_stall until every request asserted in the current cycle has completed.
- Sits between the core's MEM/IF stages and the bus interconnect.

---
 rtl/axi_core_arbiter.sv | 121 ++++++++++++
 tb/tb_axi_core_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_core_arbiter.sv
// axi_core_arbiter: serializes store/load/fetch requests onto a single AXI4-Lite-style master port.
// bus_err is registered, so its one-cycle pulse lines up with the cycle the captured data becomes visible.
module axi_core_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_mem_wr,
    input  logic [DATA_W-1:0] data_mem_wr,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] addr_mem_rd,
    input  logic              mem_rd_en,
    output logic [DATA_W-1:0] data_mem_rd,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instr_rd_en,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr,
    output logic              core_stall,
    output logic              bus_err,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arid,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rid
);
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D} state_t;

    state_t     state, state_n;
    logic [2:0] served, pending;
    logic       aw_done, w_done, aw_fin, w_fin, b_fire, r_fire;

    assign pending    = {mem_wr_en, mem_rd_en, instr_rd_en} & ~served;
    assign core_stall = |pending;
    assign aw_fin     = aw_done | awready;
    assign w_fin      = w_done | wready;
    assign b_fire     = (state == WR_B) & bvalid;
    assign r_fire     = (state == RD_D) & rvalid;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state: grant only from IDLE, store > load > fetch
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = pending[2] ? WR : (|pending[1:0] ? RD_A : IDLE);
            WR:      state_n = (aw_fin && w_fin) ? WR_B : WR;
            WR_B:    state_n = bvalid ? IDLE : WR_B;
            RD_A:    state_n = arready ? RD_D : RD_A;
            RD_D:    state_n = rvalid ? IDLE : RD_D;
            default: state_n = IDLE;
        endcase
    end

    // handshake outputs decoded from state and per-channel completion flags
    always_comb begin
        awvalid = (state == WR) && !aw_done;
        wvalid  = (state == WR) && !w_done;
        bready  = (state == WR_B);
        arvalid = (state == RD_A);
        rready  = (state == RD_D);
    end

    // payload registers, channel completion, captured data, served flags and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr      <= '0;
            wdata       <= '0;
            wstrb       <= '0;
            araddr      <= '0;
            arid        <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            data_mem_rd <= '0;
            instr       <= '0;
            instr_addr  <= '0;
            served      <= 3'b000;
            bus_err     <= 1'b0;
        end else begin
            if (state == IDLE && pending[2]) begin
                awaddr <= addr_mem_wr;
                wdata  <= data_mem_wr;
                wstrb  <= '1;
            end else if (state == IDLE && pending[1]) begin
                araddr <= addr_mem_rd;
                arid   <= 1'b1;
            end else if (state == IDLE && pending[0]) begin
                araddr <= pc;
                arid   <= 1'b0;
            end
            aw_done <= (state == WR) && (state_n == WR) && aw_fin;
            w_done  <= (state == WR) && (state_n == WR) && w_fin;
            if (r_fire && rid) data_mem_rd <= rdata;
            if (r_fire && !rid) begin
                instr      <= rdata;
                instr_addr <= araddr;
            end
            served  <= (core_stall ? served : 3'b000) | {b_fire, r_fire & rid, r_fire & ~rid};
            bus_err <= (b_fire && bresp != 2'b00) || (r_fire && rresp != 2'b00);
        end
    end
endmodule

// File: tb/tb_axi_core_arbiter.sv
// tb_axi_core_arbiter: table-driven, random and hand-written checks of axi_core_arbiter against a parametric AXI slave.
module tb_axi_core_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] addr_mem_wr = '0, data_mem_wr = '0, addr_mem_rd = '0, pc = '0;
    logic        mem_wr_en = 1'b0, mem_rd_en = 1'b0, instr_rd_en = 1'b0;
    logic [63:0] data_mem_rd, instr_addr, instr, awaddr, wdata, araddr, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        core_stall, bus_err, awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, arid, rvalid, rready, rid;

    int n_checks = 0, n_fail = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit err_st = 0, err_ld = 0, err_fe = 0;
    logic [63:0] s_araddr = '0;
    logic        s_arid = 1'b0;

    typedef struct {
        int          kind;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        id;
    } txn_t;
    txn_t       log_q[$];
    logic [4:0] trace_q[$];

    typedef struct {
        bit          st, ld, fe;
        logic [63:0] wa, wd, ra, p;
        int          awd, wdl, ard, rdl;
        bit          est, eld, efe;
        int          exp_stall, exp_err;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    axi_core_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .addr_mem_wr(addr_mem_wr), .data_mem_wr(data_mem_wr), .mem_wr_en(mem_wr_en),
        .addr_mem_rd(addr_mem_rd), .mem_rd_en(mem_rd_en), .data_mem_rd(data_mem_rd),
        .pc(pc), .instr_rd_en(instr_rd_en), .instr_addr(instr_addr), .instr(instr),
        .core_stall(core_stall), .bus_err(bus_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid)
    );

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return (a == 64'h8000_0000) ? 64'h13 : {a[31:0] ^ 32'hC0DE_F00D, ~a[31:0]};
    endfunction

    // slave: readies after a programmable number of valid cycles, responses follow the DUT's ready
    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign bvalid  = bready;
    assign bresp   = err_st ? 2'b10 : 2'b00;
    assign rvalid  = rready && (r_cnt >= r_dly);
    assign rid     = s_arid;
    assign rdata   = mem_fn(s_araddr);
    assign rresp   = (s_arid ? err_ld : err_fe) ? 2'b10 : 2'b00;

    always @(posedge clk) begin
        aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
        w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
        ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
        r_cnt  <= (rready && !rvalid) ? r_cnt + 1 : 0;
        if (rst_n && awvalid && awready) log_q.push_back('{0, awaddr, wdata, wstrb, 1'b0});
        if (rst_n && arvalid && arready) begin
            log_q.push_back('{1, araddr, 64'h0, 8'h0, arid});
            s_araddr <= araddr;
            s_arid   <= arid;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // valid must persist and payload stay stable until the handshake completes
    logic        p_rst = 1'b0, p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic [63:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    always @(negedge clk) begin
        if (rst_n && p_rst && p_arv && !p_arr) begin
            check("arvalid_hold", arvalid, 1);
            check("araddr_stable", araddr, p_araddr);
        end
        if (rst_n && p_rst && p_awv && !p_awr) begin
            check("awvalid_hold", awvalid, 1);
            check("awaddr_stable", awaddr, p_awaddr);
        end
        if (rst_n && p_rst && p_wv && !p_wr) begin
            check("wvalid_hold", wvalid, 1);
            check("wdata_stable", wdata, p_wdata);
        end
        p_rst = rst_n; p_arv = arvalid; p_arr = arready; p_araddr = araddr;
        p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
        p_wv = wvalid; p_wr = wready; p_wdata = wdata;
    end

    task automatic run_req(input bit st, input bit ld, input bit fe, input logic [63:0] wa, input logic [63:0] wd,
                           input logic [63:0] ra, input logic [63:0] p, output int stall_cyc, output int err_cyc);
        bit done = 0;
        log_q.delete();
        trace_q.delete();
        addr_mem_wr = wa; data_mem_wr = wd; addr_mem_rd = ra; pc = p;
        mem_wr_en = st; mem_rd_en = ld; instr_rd_en = fe;
        stall_cyc = 0;
        err_cyc = 0;
        #1;
        for (int i = 0; i < 400; i++) begin
            trace_q.push_back({awvalid, wvalid, bready, arvalid, rready});
            if (bus_err) err_cyc++;
            if (!core_stall) begin
                done = 1;
                break;
            end
            stall_cyc++;
            @(negedge clk);
        end
        check("stall_release_in_budget", done, 1);
        mem_wr_en = 0; mem_rd_en = 0; instr_rd_en = 0;
        @(negedge clk);
    endtask

    task automatic verify(input bit st, input bit ld, input bit fe, input logic [63:0] wa, input logic [63:0] wd,
                          input logic [63:0] ra, input logic [63:0] p);
        txn_t exp_q[$];
        if (st) exp_q.push_back('{0, wa, wd, 8'hFF, 1'b0});
        if (ld) exp_q.push_back('{1, ra, 64'h0, 8'h0, 1'b1});
        if (fe) exp_q.push_back('{1, p, 64'h0, 8'h0, 1'b0});
        check("txn_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("txn_kind", log_q[i].kind, exp_q[i].kind);
            check("txn_addr", log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].kind == 0) begin
                check("txn_wdata", log_q[i].data, exp_q[i].data);
                check("txn_wstrb", log_q[i].strb, exp_q[i].strb);
            end else check("txn_arid", log_q[i].id, exp_q[i].id);
        end
        if (ld) check("data_mem_rd", data_mem_rd, mem_fn(ra));
        if (fe) begin
            check("instr", instr, mem_fn(p));
            check("instr_addr", instr_addr, p);
        end
        check("bus_err_after", bus_err, 0);
    endtask

    function automatic void set_slave(input int awd, input int wdl, input int ard, input int rdl,
                                      input bit est, input bit eld, input bit efe);
        aw_dly = awd; w_dly = wdl; ar_dly = ard; r_dly = rdl;
        err_st = est; err_ld = eld; err_fe = efe;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        int sc, ec, exp_s, exp_e, ar_cyc;
        logic [4:0] exp_tr[6];
        bit seen;
        tbl[0] = '{0, 0, 1, 64'h0, 64'h0, 64'h0, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 3, 0};
        tbl[1] = '{1, 0, 0, 64'h100, 64'hDEAD_BEEF, 64'h0, 64'h0, 0, 2, 0, 0, 0, 0, 0, 5, 0};
        tbl[2] = '{1, 1, 1, 64'h100, 64'hDEAD_BEEF, 64'h2000, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 9, 0};
        tbl[3] = '{0, 1, 0, 64'h0, 64'h0, 64'h3000, 64'h0, 0, 0, 5, 0, 0, 0, 0, 8, 0};
        tbl[4] = '{0, 1, 0, 64'h0, 64'h0, 64'h4000, 64'h0, 0, 0, 0, 0, 0, 1, 0, 3, 1};
        tbl[5] = '{1, 0, 1, 64'h208, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h8000_0040, 3, 1, 0, 0, 1, 0, 0, 9, 1};
        tbl[6] = '{0, 1, 1, 64'h0, 64'h0, 64'h6000, 64'h8000_0080, 0, 0, 0, 2, 0, 0, 1, 10, 1};
        tbl[7] = '{0, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_core_stall", core_stall, 0);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_instr", instr, 0);
        check("rst_data_mem_rd", data_mem_rd, 0);
        check("rst_instr_addr", instr_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            set_slave(tbl[k].awd, tbl[k].wdl, tbl[k].ard, tbl[k].rdl, tbl[k].est, tbl[k].eld, tbl[k].efe);
            run_req(tbl[k].st, tbl[k].ld, tbl[k].fe, tbl[k].wa, tbl[k].wd, tbl[k].ra, tbl[k].p, sc, ec);
            check("tbl_stall_cycles", sc, tbl[k].exp_stall);
            check("tbl_bus_err_pulses", ec, tbl[k].exp_err);
            verify(tbl[k].st, tbl[k].ld, tbl[k].fe, tbl[k].wa, tbl[k].wd, tbl[k].ra, tbl[k].p);
            if (k == 0) check("fetch_instr_0x13", instr, 64'h13);
        end

        exp_tr = '{5'b00000, 5'b11000, 5'b01000, 5'b01000, 5'b00100, 5'b00000};
        set_slave(0, 2, 0, 0, 0, 0, 0);
        run_req(1, 0, 0, 64'h100, 64'hDEAD_BEEF, 64'h0, 64'h0, sc, ec);
        check("wlag_trace_len", trace_q.size(), 6);
        for (int i = 0; i < 6 && i < trace_q.size(); i++) check("wlag_aw_w_b_trace", trace_q[i], exp_tr[i]);

        set_slave(0, 0, 5, 0, 0, 0, 0);
        run_req(0, 1, 0, 64'h0, 64'h0, 64'h7000, 64'h0, sc, ec);
        ar_cyc = 0;
        foreach (trace_q[i]) if (trace_q[i][1]) ar_cyc++;
        check("arstall_arvalid_cycles", ar_cyc, 6);
        check("arstall_single_ar", log_q.size(), 1);

        for (int it = 0; it < 30; it++) begin
            bit st, ld, fe, est, eld, efe;
            int awd, wdl, ard, rdl;
            logic [63:0] wa, wd, ra, p;
            st = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1)); fe = 1'($urandom_range(0, 1));
            awd = $urandom_range(0, 3); wdl = $urandom_range(0, 3); ard = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
            est = ($urandom_range(0, 3) == 0); eld = ($urandom_range(0, 3) == 0); efe = ($urandom_range(0, 3) == 0);
            wa = {$urandom, $urandom}; wd = {$urandom, $urandom}; ra = {$urandom, $urandom}; p = {$urandom, $urandom};
            exp_s = (st ? 3 + (awd > wdl ? awd : wdl) : 0) + (ld ? 3 + ard + rdl : 0) + (fe ? 3 + ard + rdl : 0);
            exp_e = int'(st & est) + int'(ld & eld) + int'(fe & efe);
            set_slave(awd, wdl, ard, rdl, est, eld, efe);
            run_req(st, ld, fe, wa, wd, ra, p, sc, ec);
            check("rand_stall_cycles", sc, exp_s);
            check("rand_bus_err_pulses", ec, exp_e);
            verify(st, ld, fe, wa, wd, ra, p);
        end

        set_slave(0, 0, 0, 20, 0, 0, 0);
        addr_mem_rd = 64'h5000;
        mem_rd_en = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rready) begin
                seen = 1;
                break;
            end
        end
        check("reach_rd_d", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_arvalid", arvalid, 0);
        check("rst_mid_rready", rready, 0);
        check("rst_mid_data_mem_rd", data_mem_rd, 0);
        mem_rd_en = 0;
        #1;
        check("rst_mid_core_stall", core_stall, 0);
        set_slave(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_core_stall", core_stall, 0);
        check("post_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        run_req(0, 0, 1, 64'h0, 64'h0, 64'h0, 64'h8000_0100, sc, ec);
        check("post_rst_fetch_stall", sc, 3);
        verify(0, 0, 1, 64'h0, 64'h0, 64'h0, 64'h8000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
